// File: rtl/branch_pkg.sv
// Shared branch definitions: opcode constants, FSM state type and branch decode.
package branch_pkg;

    localparam logic [5:0] OP_BEQ = 6'h08;
    localparam logic [5:0] OP_BNE = 6'h09;
    localparam logic [5:0] OP_BGE = 6'h0A;
    localparam logic [5:0] OP_BGT = 6'h0B;
    localparam logic [5:0] OP_BLE = 6'h0C;
    localparam logic [5:0] OP_BLT = 6'h0D;

    typedef enum logic [1:0] {
        StIdle,
        StWaitCmp,
        StRedirect,
        StFlush
    } br_state_t;

    // Branch opcodes occupy one contiguous range.
    function automatic logic is_branch(input logic [5:0] opcode);
        return (opcode >= OP_BEQ) && (opcode <= OP_BLT);
    endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Bus between decode/compare/fetch and the branch redirect unit.
interface branch_redirect_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic [31:0]      ir;
    logic [31:0]      pc;
    logic             branch_yes;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ready;
    logic             flush;
    logic             stall;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    // Environment side: decode, comparator and fetch.
    modport master (
        output br_valid, ir, pc, branch_yes, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flush, stall, br_count, taken_count
    );

    // Unit side.
    modport slave (
        input  br_valid, ir, pc, branch_yes, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flush, stall, br_count, taken_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count up on inc, hold once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/branch_redirect_unit.sv
// Turns taken branches into a fetch redirect followed by a fixed flush window.
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_unit_if.slave  bus
);

    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FlushW-1:0] FlushLoad =
        FlushW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    br_state_t         r_state;
    br_state_t         w_state_next;
    logic [31:0]       r_target;
    logic [31:0]       r_redirect_pc;
    logic [FlushW-1:0] r_flush_cnt;

    logic              w_br_inc;
    logic              w_taken_inc;
    logic [31:0]       w_target;
    logic [CNT_W-1:0]  w_br_count;
    logic [CNT_W-1:0]  w_taken_count;
    logic              w_unused_ir;

    assign w_br_inc    = (r_state == StIdle) && bus.br_valid && is_branch(bus.ir[31:26]);
    assign w_taken_inc = (r_state == StWaitCmp) && bus.branch_yes;

    // Word offset sign-extended and scaled to bytes; wraps modulo 2^32.
    assign w_target    = bus.pc + 32'd4 + {{14{bus.ir[15]}}, bus.ir[15:0], 2'b00};
    assign w_unused_ir = ^bus.ir[25:16];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Target, visible redirect address and flush countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target      <= '0;
            r_redirect_pc <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_br_inc) begin
                r_target <= w_target;
            end
            // Only a taken branch moves redirect_pc, so it holds across not-taken ones.
            if (w_taken_inc) begin
                r_redirect_pc <= r_target;
            end
            if ((r_state == StRedirect) && bus.redirect_ready) begin
                r_flush_cnt <= FlushLoad;
            end else if ((r_state == StFlush) && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_br_inc) begin
                    w_state_next = StWaitCmp;
                end
            end
            StWaitCmp: begin
                w_state_next = bus.branch_yes ? StRedirect : StIdle;
            end
            StRedirect: begin
                if (bus.redirect_ready) begin
                    w_state_next = (FLUSH_CYCLES == 0) ? StIdle : StFlush;
                end
            end
            StFlush: begin
                if (r_flush_cnt == '0) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.br_ready       = (r_state == StIdle);
        bus.stall          = (r_state != StIdle);
        bus.redirect_valid = (r_state == StRedirect);
        bus.flush          = (r_state == StFlush);
        bus.redirect_pc    = r_redirect_pc;
        bus.br_count       = w_br_count;
        bus.taken_count    = w_taken_count;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_br_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_br_inc),
        .q     (w_br_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_taken_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_taken_inc),
        .q     (w_taken_count)
    );

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Consumes the registered `branch_yes` decision from the branch comparator and turns taken branches into a PC redirect for fetch, followed by a fixed flush window. It sits between decode/compare and the fetch PC mux. It owns branch-target arithmetic, the redirect handshake, flush sequencing and branch statistics counters.

## Interface
- `FLUSH_CYCLES`, 2, cycles `flush` is held after a redirect is accepted; 0 allowed.
- `CNT_W`, 16, width of the statistics counters.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `br_valid`  in  1  `ir`/`pc` valid this cycle.
- `br_ready`  out  1  unit can accept; high only in IDLE.
- `ir`  in  32  instruction word; opcode = `ir[31:26]`, offset = `ir[15:0]`.
- `pc`  in  32  address of the instruction in `ir`.
- `branch_yes`  in  1  comparator decision, valid exactly one cycle after acceptance.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  target address; stable while `redirect_valid`.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush`  out  1  kill younger in-flight instructions.
- `stall`  out  1  high whenever state is not IDLE.
- `br_count`  out  CNT_W  branches accepted; saturating.
- `taken_count`  out  CNT_W  branches resolved taken; saturating.

## Operation
- Branch opcodes are 6'h08–6'h0D (BEQ, BNE, BGE, BGT, BLE, BLT).
- The FSM has four states: IDLE, WAIT_CMP, REDIRECT, FLUSH.
- **IDLE**
  - A transfer is `br_valid && br_ready`.
  - Branch opcode: latch `target = pc + 4 + (sext(ir[15:0]) << 2)`, increment `br_count`, go to WAIT_CMP.
  - Non-branch opcode: the transfer is consumed silently and the state stays IDLE.
- **WAIT_CMP**
  - Sample `branch_yes` once.
  - `branch_yes` = 1: increment `taken_count`, go to REDIRECT.
  - `branch_yes` = 0: go to IDLE.
- **REDIRECT**
  - `redirect_valid` = 1 and `redirect_pc` = the latched target.
  - On `redirect_ready`: go to FLUSH with the counter loaded to FLUSH_CYCLES−1.
  - If FLUSH_CYCLES = 0, go to IDLE instead.
  - `redirect_ready` while `redirect_valid` is low has no effect.
- **FLUSH**
  - `flush` = 1; the counter decrements each cycle.
  - Counter at 0: go to IDLE.
- Arithmetic and counters:
  - Target addition is modulo 2^32. A wrap past 32'hFFFFFFFC is legal and is not flagged.
  - Both counters saturate at all-ones and never wrap.
  - If both counters increment in the same cycle, each updates independently.

## Timing
- Reset values: state IDLE, `br_ready`=1, `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `stall`=0, both counters 0.
- Reset mid-operation aborts any pending redirect or flush immediately. No redirect is emitted after release.
- All outputs are decoded from registered state and registers only. There is no combinational path from inputs to outputs.
- Timeline for a transfer accepted at edge k:
  - `branch_yes` is sampled at edge k+1.
  - `redirect_valid` is high from edge k+1 until the edge where `redirect_ready` is seen.
  - `flush` is high for exactly FLUSH_CYCLES cycles after that edge.
  - `br_ready` returns high on the following edge.
- Latency:
  - Not-taken branch: `br_ready` low for exactly 1 cycle.
  - Taken branch with zero wait on `redirect_ready`: `br_ready` low for 2 + FLUSH_CYCLES cycles.
- `redirect_pc` holds its value after the handshake until the next taken branch.

## Structure
- Shared package `branch_pkg`:
  - opcode constants `OP_BEQ`..`OP_BLT` (6'h08..6'h0D)
  - state enum `br_state_t`
  - function `is_branch(opcode)`
- The comparator uses the same opcode constants.
- One sub-module: `sat_counter` (parameter W; ports `clk`, `rst_n`, `inc`, `q`). Instantiate it twice, for `br_count` and `taken_count`.
- Target arithmetic stays inline.

## Test plan
- Reset mid-REDIRECT (`redirect_ready` held 0), then release -> all outputs at reset values; no `redirect_valid` afterwards.
- `pc`=32'h0000_1000, `ir`=BEQ, offset 16'h0004, `branch_yes`=1, `redirect_ready`=1 -> `redirect_pc`=32'h0000_1014; `flush` high for 2 cycles; `br_count`=`taken_count`=1.
- `pc`=32'h0000_0100, BNE, offset 16'hFFFE, `branch_yes`=0 -> no `redirect_valid`; `br_ready` low for 1 cycle; `br_count`=1, `taken_count`=0.
- Taken BLT with `redirect_ready` low for 3 cycles -> `redirect_valid` held 3+1 cycles; `redirect_pc` stable; `stall` high throughout; `br_valid` ignored.
- `ir` opcode 6'h00 with `br_valid` -> stays IDLE, counters unchanged. Repeat with `pc`=32'hFFFF_FFF8, offset 16'h0001, taken -> `redirect_pc`=32'h0000_0000.
- CNT_W=2: 5 taken branches -> both counters saturate at 3.
